matmul_loader: RTL and testbench
================================

MATMUL_LOADER -- requirements
Module: matmul_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the stream and BRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the BRAM address width.
REQ-003 Parameter VECTOR_SIZE, default 64, SHALL set the matrix dimension; N = VECTOR_SIZE*VECTOR_SIZE words per operand, N <= 2**ADDR_WIDTH.
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port reset, input, 1, SHALL be synchronous, active-high reset.
REQ-006 Port in_data, input, DATA_WIDTH, SHALL carry the operand stream word.
REQ-007 Port in_valid, input, 1, SHALL indicate that in_data is valid.
REQ-008 Port in_ready, output, 1, SHALL indicate that the loader accepts a word this cycle.
REQ-009 Ports x_din/x_wr_addr/x_wr_en, outputs, DATA_WIDTH/ADDR_WIDTH/1, SHALL drive the x BRAM write port.
REQ-010 Ports y_din/y_wr_addr/y_wr_en, outputs, DATA_WIDTH/ADDR_WIDTH/1, SHALL drive the y BRAM write port.
REQ-011 Port start, output, 1, SHALL launch the multiplier; port done, input, 1, SHALL be the multiplier completion level.
REQ-012 Port busy, output, 1, SHALL be high in every state except LOAD_X with zero words accepted.
REQ-013 Port complete, output, 1, SHALL pulse for one cycle per finished multiply.
REQ-014 Port cycle_count, output, 32, SHALL report the cycle counter (REQ-030).

Function
REQ-015 A transfer SHALL occur on a cycle where in_valid and in_ready are both high.
REQ-016 States SHALL be LOAD_X, LOAD_Y, START, WAIT_LOW, WAIT_HIGH.
REQ-017 in_ready SHALL be high combinationally in LOAD_X and LOAD_Y only, and SHALL not depend on in_valid.
REQ-018 In LOAD_X, each transfer SHALL register x_din=in_data, x_wr_addr=word index, x_wr_en=1 for exactly the following cycle (1-cycle write latency).
REQ-019 Word index SHALL start at 0, increment by 1 per transfer, and clear to 0 after index N-1.
REQ-020 The transfer at index N-1 in LOAD_X SHALL move to LOAD_Y; the next transfer SHALL write y at address 0.
REQ-021 LOAD_Y SHALL write y identically to REQ-018; the transfer at index N-1 SHALL move to START.
REQ-022 START SHALL last one cycle with start=1, then move to WAIT_LOW; start SHALL be 0 in all other states.
REQ-023 WAIT_LOW SHALL move to WAIT_HIGH on the first cycle done=0; a stale high done SHALL therefore not end the run.
REQ-024 WAIT_HIGH SHALL, on the first cycle done=1, assert complete on the next cycle and move to LOAD_X.
REQ-025 in_valid gaps SHALL stall the index without writing; x_wr_en/y_wr_en SHALL be 0 on cycles with no transfer.
REQ-026 The final y write (index N-1) SHALL be issued in the same cycle as start=1.
REQ-027 done SHALL be ignored in LOAD_X, LOAD_Y and START.

Reset
REQ-028 While reset=1: state=LOAD_X, index=0, in_ready=0, start=0, complete=0, busy=0, x_wr_en=y_wr_en=0, x/y din and addr=0, cycle_count=0.
REQ-029 Reset asserted mid-operation SHALL abandon the load or run within one cycle; no write or start SHALL issue in the cycle after reset deasserts, and in_ready SHALL rise one cycle after deassertion.

Configuration
REQ-030 With macro MATMUL_LOADER_CYCLE_CNT_EN defined, a 32-bit counter SHALL clear on entering START, increment every cycle in START, WAIT_LOW and WAIT_HIGH, saturate at 2**32-1, and hold its value in the LOAD states; cycle_count SHALL equal the counter.
REQ-031 Without MATMUL_LOADER_CYCLE_CNT_EN, no counter SHALL be built and cycle_count SHALL be constant 0.

Verification (VECTOR_SIZE=4, N=16)
REQ-032 Stream 32 words 1..32 with in_valid held high -> x[0..15]=1..16, y[0..15]=17..32, start=1 exactly one cycle, in the cycle of the y[15] write.
REQ-033 Same stream with in_valid toggling 1,0,1,0 -> identical BRAM contents, no write on idle cycles, index never skips.
REQ-034 done held high from start through 5 cycles after, then 0 for 3 cycles, then 1 -> exactly one complete pulse, one cycle after the second done rise.
REQ-035 Reset asserted after 10 x words -> all outputs at reset values; a fresh 32-word stream then writes x from address 0.
REQ-036 With the macro, done rises 20 cycles after start (after dropping low) -> cycle_count=21 at the complete pulse; without the macro -> cycle_count=0 throughout.
REQ-037 Two back-to-back 32-word loads -> second load accepted only after the first complete pulse, with in_ready=0 from START until LOAD_X re-entry.

Source files
------------

// File: rtl/matmul_loader.sv
// Streams the x and y operands of a VECTOR_SIZE x VECTOR_SIZE multiply into two BRAMs,
// launches the multiplier and waits for its done level. Optional: MATMUL_LOADER_CYCLE_CNT_EN.
module matmul_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int VECTOR_SIZE = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic                  y_wr_en,
    output logic                  start,
    input  logic                  done,
    output logic                  busy,
    output logic                  complete,
    output logic [31:0]           cycle_count
);
    localparam int N = VECTOR_SIZE * VECTOR_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    typedef enum logic [2:0] {
        LOAD_X,
        LOAD_Y,
        START,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] index_reg;
    logic                  ready_en_reg;
    logic [DATA_WIDTH-1:0] x_din_reg;
    logic [ADDR_WIDTH-1:0] x_wr_addr_reg;
    logic                  x_wr_en_reg;
    logic [DATA_WIDTH-1:0] y_din_reg;
    logic [ADDR_WIDTH-1:0] y_wr_addr_reg;
    logic                  y_wr_en_reg;
    logic                  start_reg;
    logic                  complete_reg;

    logic load_state;
    logic transfer;
    logic last_word;

    // ready_en_reg holds in_ready low for the first cycle after reset is released
    assign load_state = (state_reg == LOAD_X) || (state_reg == LOAD_Y);
    assign in_ready   = ready_en_reg && load_state && !reset;
    assign transfer   = in_valid && in_ready;
    assign last_word  = (index_reg == LAST_IDX);
    assign busy       = !((state_reg == LOAD_X) && (index_reg == '0));

    assign x_din     = x_din_reg;
    assign x_wr_addr = x_wr_addr_reg;
    assign x_wr_en   = x_wr_en_reg;
    assign y_din     = y_din_reg;
    assign y_wr_addr = y_wr_addr_reg;
    assign y_wr_en   = y_wr_en_reg;
    assign start     = start_reg;
    assign complete  = complete_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= LOAD_X;
            index_reg     <= '0;
            ready_en_reg  <= 1'b0;
            x_din_reg     <= '0;
            x_wr_addr_reg <= '0;
            x_wr_en_reg   <= 1'b0;
            y_din_reg     <= '0;
            y_wr_addr_reg <= '0;
            y_wr_en_reg   <= 1'b0;
            start_reg     <= 1'b0;
            complete_reg  <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            x_wr_en_reg  <= 1'b0;
            y_wr_en_reg  <= 1'b0;
            start_reg    <= 1'b0;
            complete_reg <= 1'b0;
            case (state_reg)
                LOAD_X: begin
                    if (transfer) begin
                        x_din_reg     <= in_data;
                        x_wr_addr_reg <= index_reg;
                        x_wr_en_reg   <= 1'b1;
                        if (last_word) begin
                            index_reg <= '0;
                            state_reg <= LOAD_Y;
                        end else begin
                            index_reg <= index_reg + ADDR_WIDTH'(1);
                        end
                    end
                end
                LOAD_Y: begin
                    if (transfer) begin
                        y_din_reg     <= in_data;
                        y_wr_addr_reg <= index_reg;
                        y_wr_en_reg   <= 1'b1;
                        if (last_word) begin
                            index_reg <= '0;
                            state_reg <= START;
                            start_reg <= 1'b1;
                        end else begin
                            index_reg <= index_reg + ADDR_WIDTH'(1);
                        end
                    end
                end
                START: begin
                    state_reg <= WAIT_LOW;
                end
                // A done level left high from the previous run must drop before it counts
                WAIT_LOW: begin
                    if (!done) begin
                        state_reg <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (done) begin
                        complete_reg <= 1'b1;
                        state_reg    <= LOAD_X;
                    end
                end
                default: begin
                    state_reg <= LOAD_X;
                end
            endcase
        end
    end

`ifdef MATMUL_LOADER_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_reg;
    logic        run_state;

    assign run_state = (state_reg == START) || (state_reg == WAIT_LOW) || (state_reg == WAIT_HIGH);

    // Cleared on the edge into START so the START cycle reads 0
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt_reg <= '0;
        end else if ((state_reg == LOAD_Y) && transfer && last_word) begin
            cycle_cnt_reg <= '0;
        end else if (run_state && (cycle_cnt_reg != 32'hFFFF_FFFF)) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt_reg;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader with VECTOR_SIZE=4 (16 words per operand).
module tb_matmul_loader;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int VS = 4;
    localparam int N  = VS * VS;
`ifdef MATMUL_LOADER_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          done = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_din;
    logic [AW-1:0] x_wr_addr;
    logic          x_wr_en;
    logic [DW-1:0] y_din;
    logic [AW-1:0] y_wr_addr;
    logic          y_wr_en;
    logic          start;
    logic          busy;
    logic          complete;
    logic [31:0]   cycle_count;

    matmul_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .VECTOR_SIZE(VS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_din      (x_din),
        .x_wr_addr  (x_wr_addr),
        .x_wr_en    (x_wr_en),
        .y_din      (y_din),
        .y_wr_addr  (y_wr_addr),
        .y_wr_en    (y_wr_en),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .complete   (complete),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] x_mem [N];
    logic [31:0] y_mem [N];
    int          cyc = 0;
    bit          mon_on = 1'b0;
    bit          prev_xfer = 1'b0;
    int          exp_x_addr = 0;
    int          exp_y_addr = 0;
    int          start_count = 0;
    int          comp_count = 0;
    int          start_cyc = 0;
    int          comp_cyc = 0;
    logic [31:0] cc_at_complete = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // BRAM model and protocol monitor, sampled on the falling edge
    always @(negedge clock) begin
        cyc++;
        if (mon_on) begin
            check("wr_vs_xfer", 32'(x_wr_en | y_wr_en), 32'(prev_xfer));
            if (x_wr_en) begin
                check("x_addr_seq", 32'(x_wr_addr), 32'(exp_x_addr));
                x_mem[x_wr_addr[3:0]] = x_din;
                $display("  x[%0d] <= %0d", x_wr_addr, x_din);
                exp_x_addr = (exp_x_addr + 1) % N;
            end
            if (y_wr_en) begin
                check("y_addr_seq", 32'(y_wr_addr), 32'(exp_y_addr));
                y_mem[y_wr_addr[3:0]] = y_din;
                $display("  y[%0d] <= %0d", y_wr_addr, y_din);
                exp_y_addr = (exp_y_addr + 1) % N;
            end
            if (start) begin
                start_count++;
                start_cyc = cyc;
                check("start_with_y_wr", 32'(y_wr_en), 32'd1);
                check("start_y_addr", 32'(y_wr_addr), 32'(N - 1));
            end
            if (complete) begin
                comp_count++;
                comp_cyc = cyc;
                cc_at_complete = cycle_count;
                $display("  complete at cycle %0d, cycle_count=%0d", cyc, cycle_count);
            end
            if (reset) begin
                exp_x_addr = 0;
                exp_y_addr = 0;
            end
        end
        prev_xfer = in_valid && in_ready;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] val);
        int waited = 0;
        in_data  = val;
        in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("push_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < N; i++) begin
            x_mem[i] = '0;
            y_mem[i] = '0;
        end
    endtask

    task automatic check_mems(input string p, input int xbase, input int ybase);
        for (int i = 0; i < N; i++) begin
            check({p, "_x_mem"}, x_mem[i], 32'(xbase + i));
            check({p, "_y_mem"}, y_mem[i], 32'(ybase + i));
        end
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_in_ready"}, 32'(in_ready), 32'd0);
        check({p, "_start"}, 32'(start), 32'd0);
        check({p, "_complete"}, 32'(complete), 32'd0);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_x_wr_en"}, 32'(x_wr_en), 32'd0);
        check({p, "_y_wr_en"}, 32'(y_wr_en), 32'd0);
        check({p, "_x_din"}, x_din, 32'd0);
        check({p, "_x_wr_addr"}, 32'(x_wr_addr), 32'd0);
        check({p, "_y_din"}, y_din, 32'd0);
        check({p, "_y_wr_addr"}, 32'(y_wr_addr), 32'd0);
        check({p, "_cycle_count"}, cycle_count, 32'd0);
    endtask

    // Called at posedge+1 of the second reset cycle; leaves in_valid low
    task automatic release_reset(input string p);
        reset = 1'b0;
        @(negedge clock);
        check({p, "_ready_first"}, 32'(in_ready), 32'd0);
        check({p, "_no_write_first"}, 32'(x_wr_en | y_wr_en), 32'd0);
        check({p, "_no_start_first"}, 32'(start), 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check({p, "_ready_second"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_complete(input string p, input int exp_lat);
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (complete) break;
        end
        check({p, "_complete_seen"}, 32'(complete), 32'd1);
        check({p, "_busy_at_complete"}, 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        check({p, "_complete_width"}, 32'(complete), 32'd0);
        check({p, "_latency"}, 32'(comp_cyc - start_cyc), 32'(exp_lat));
        check({p, "_cycle_count"}, cc_at_complete, CNT_EN ? 32'(exp_lat) : 32'd0);
        check({p, "_start_pulses"}, 32'(start_count), 32'd1);
        check({p, "_complete_pulses"}, 32'(comp_count), 32'd1);
        start_count = 0;
        comp_count  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and release
        reset = 1'b1;
        wait_cycles(3);
        @(negedge clock);
        check_reset_outputs("rst");
        mon_on = 1'b1;
        @(posedge clock);
        #1;
        release_reset("rel");

        // Held-valid stream with done high from start, dropping low, then rising again
        clear_mems();
        done = 1'b1;
        for (int i = 1; i <= 2 * N; i++) push_word(32'(i));
        @(negedge clock);
        check("a_start", 32'(start), 32'd1);
        check("a_ready_in_start", 32'(in_ready), 32'd0);
        check("a_busy_in_start", 32'(busy), 32'd1);
        check("a_last_y_din", y_din, 32'd32);
        wait_cycles(6);
        done = 1'b0;
        wait_cycles(3);
        done = 1'b1;
        wait_complete("a", 10);
        check_mems("a", 1, 17);

        // Toggling valid; stale done high must not end the run
        clear_mems();
        @(negedge clock);
        check("b_cc_hold_idle", cycle_count, CNT_EN ? 32'd10 : 32'd0);
        check("b_busy_idle", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        for (int i = 1; i <= 2 * N; i++) begin
            push_word(32'(i));
            if (i == 1) begin
                @(negedge clock);
                check("b_busy_loading", 32'(busy), 32'd1);
                check("b_cc_hold_load", cycle_count, CNT_EN ? 32'd10 : 32'd0);
            end
            if (i < 2 * N) wait_cycles(1);
        end
        wait_cycles(4);
        done = 1'b0;
        wait_cycles(16);
        done = 1'b1;
        wait_complete("b", 21);
        check_mems("b", 1, 17);

        // Reset after 10 x words, with in_valid held high through the reset
        clear_mems();
        for (int i = 1; i <= 10; i++) push_word(32'(i));
        in_valid = 1'b1;
        in_data  = 32'd99;
        reset    = 1'b1;
        wait_cycles(1);
        @(negedge clock);
        check_reset_outputs("mid");
        @(posedge clock);
        #1;
        release_reset("c_rel");
        for (int i = 0; i < 2 * N; i++) push_word(32'(201 + i));
        done = 1'b0;
        wait_cycles(2);
        done = 1'b1;
        wait_complete("c", 3);
        check_mems("c", 201, 217);

        // Back-to-back loads: the second stream waits for the first complete pulse
        clear_mems();
        for (int i = 0; i < 2 * N; i++) push_word(32'(301 + i));
        in_valid = 1'b1;
        in_data  = 32'd500;
        done     = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (complete) break;
            check("d_ready_while_run", 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
            if (k == 2) done = 1'b1;
        end
        check("d_complete_seen", 32'(complete), 32'd1);
        check("d_ready_at_complete", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("d1_latency", 32'(comp_cyc - start_cyc), 32'd4);
        check("d1_cycle_count", cc_at_complete, CNT_EN ? 32'd4 : 32'd0);
        check("d1_complete_pulses", 32'(comp_count), 32'd1);
        start_count = 0;
        comp_count  = 0;
        check_mems("d1", 301, 317);
        clear_mems();
        for (int i = 1; i < 2 * N; i++) push_word(32'(500 + i));
        done = 1'b0;
        wait_cycles(2);
        done = 1'b1;
        wait_complete("d2", 3);
        check_mems("d2", 500, 516);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
